mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit with HI/LO result registers for the MIPS datapath.
- Sits beside the combinational ALU in the execute stage.
- Takes signed/unsigned MULT/DIV requests through a start/busy/done handshake and computes one bit per cycle.
- Also services MTHI/MTLO writes. The pipeline stalls on `busy` before any MFHI/MFLO read.

---
 rtl/mdu_iter.sv | 183 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative MULT/DIV unit with HI/LO registers for the MIPS execute stage.
// Computes one radix-2 step per cycle; also services MTHI/MTLO writes.
module mdu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned AW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    logic [1:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [AW-1:0]    acc, acc_d;
    logic [WIDTH-1:0] dsr, dsr_d;
    logic [WIDTH-1:0] a_raw, a_raw_d;
    logic             is_div, is_div_d;
    logic             neg_q, neg_q_d;
    logic             neg_r, neg_r_d;
    logic             div0, div0_d;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             busy_d, done_d;

    // Operand conditioning for a new MULT/DIV request
    logic             sgn_c, sa_c, sb_c;
    logic [WIDTH-1:0] abs_a_c, abs_b_c;

    assign sgn_c   = ~op[0];
    assign sa_c    = sgn_c & a[WIDTH-1];
    assign sb_c    = sgn_c & b[WIDTH-1];
    assign abs_a_c = sa_c ? WIDTH'(-a) : a;
    assign abs_b_c = sb_c ? WIDTH'(-b) : b;

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
    logic [WIDTH:0]  mul_sum_c;
    logic [WIDTH:0]  div_trial_c;
    logic [AW-1:0]   step_c;

    assign mul_sum_c   = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, dsr} : '0);
    assign div_trial_c = acc[AW-1:WIDTH-1] - {1'b0, dsr};

    always_comb begin
        step_c = {mul_sum_c, acc[WIDTH-1:1]};
        if (is_div) begin
            if (div_trial_c[WIDTH]) begin
                step_c = {acc[AW-2:0], 1'b0};
            end else begin
                step_c = {div_trial_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end
    end

    // Sign fix-up of the unsigned magnitude result
    logic [AW-1:0]    prod_c;
    logic [WIDTH-1:0] quot_c, rem_c;

    assign prod_c = neg_q ? AW'(-acc) : acc;
    assign quot_c = neg_q ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    assign rem_c  = neg_r ? WIDTH'(-acc[AW-1:WIDTH]) : acc[AW-1:WIDTH];

    // Next-state and register-next logic
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        acc_d    = acc;
        dsr_d    = dsr;
        a_raw_d  = a_raw;
        is_div_d = is_div;
        neg_q_d  = neg_q;
        neg_r_d  = neg_r;
        div0_d   = div0;
        hi_d     = hi;
        lo_d     = lo;
        busy_d   = busy;
        done_d   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        state_d  = S_CALC;
                        cnt_d    = '0;
                        acc_d    = {{WIDTH{1'b0}}, abs_a_c};
                        dsr_d    = abs_b_c;
                        a_raw_d  = a;
                        is_div_d = op[1];
                        neg_q_d  = sa_c ^ sb_c;
                        neg_r_d  = sa_c;
                        div0_d   = op[1] & (b == '0);
                        busy_d   = 1'b1;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            S_CALC: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = step_c;
                    cnt_d = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (!is_div) begin
                        hi_d = prod_c[AW-1:WIDTH];
                        lo_d = prod_c[WIDTH-1:0];
                    end else if (div0) begin
                        hi_d = a_raw;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_c;
                        lo_d = quot_c;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            dsr    <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            acc    <= acc_d;
            dsr    <= dsr_d;
            a_raw  <= a_raw_d;
            is_div <= is_div_d;
            neg_q  <= neg_q_d;
            neg_r  <= neg_r_d;
            div0   <= div0_d;
            hi     <= hi_d;
            lo     <= lo_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized self-checking bench for mdu_iter against a plain-arithmetic HI/LO model.
module tb_mdu_iter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             cancel;
    logic             busy, done;
    logic [WIDTH-1:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_iter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .resetn(resetn),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cancel(cancel),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference {hi, lo} after an operation, given the current hi/lo
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, y,
                                               input logic [31:0] h, l);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin
                p = 64'(sx * sy);
                return p;
            end
            3'd1: return {32'b0, x} * {32'b0, y};
            3'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            3'd4: return {x, l};
            3'd5: return {h, x};
            default: return {h, l};
        endcase
    endfunction

    // Issue one request; inj/cnc/rst give a cycle index for an ignored start, cancel or reset (-1 = none)
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x, y,
                         input int inj, input int cnc, input int rst);
        int lat;
        bit got_done, busy_bad;
        logic [63:0] exp;
        exp = ref_result(o, x, y, m_hi, m_lo);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        if (o[2]) begin
            check({tag, " busy"}, 64'(busy), 64'd0);
            check({tag, " done"}, 64'(done), 64'd0);
            check({tag, " hilo"}, {hi, lo}, exp);
            m_hi = exp[63:32];
            m_lo = exp[31:0];
            return;
        end
        check({tag, " busy0"}, 64'(busy), 64'd1);
        lat = 0; got_done = 0; busy_bad = 0;
        while (!got_done && lat < 3 * LAT) begin
            if (lat == inj) begin
                start = 1'b1; op = 3'd2; a = $urandom; b = $urandom | 32'd1;
            end
            if (lat == cnc) cancel = 1'b1;
            if (lat == rst) resetn = 1'b0;
            @(negedge clk);
            lat++;
            start = 1'b0; cancel = 1'b0; resetn = 1'b1;
            if (lat == cnc + 1 || lat == rst + 1) break;
            if (done) got_done = 1;
            else if (!busy) busy_bad = 1;
        end
        if (cnc >= 0 || rst >= 0) begin
            if (rst >= 0) begin
                m_hi = '0;
                m_lo = '0;
            end
            check({tag, " abort busy"}, 64'(busy), 64'd0);
            check({tag, " abort done"}, 64'(done), 64'd0);
            check({tag, " abort hilo"}, {hi, lo}, {m_hi, m_lo});
            got_done = 0;
            for (int i = 0; i < LAT + 4; i++) begin
                @(negedge clk);
                if (done || busy) got_done = 1;
            end
            check({tag, " no late done"}, 64'(got_done), 64'd0);
            check({tag, " hilo held"}, {hi, lo}, {m_hi, m_lo});
            return;
        end
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        check({tag, " busy gap"}, 64'(busy_bad), 64'd0);
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        check({tag, " hilo"}, {hi, lo}, exp);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        @(negedge clk);
        check({tag, " done pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        resetn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cancel = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        resetn = 1'b1;

        do_op("mult neg", 3'd0, 32'hFFFF_FFFD, 32'h0000_0005, -1, -1, -1);
        check("mult neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op("multu max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
        check("multu max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op("divu", 3'd3, 32'd100, 32'd7, -1, -1, -1);
        check("divu const", {hi, lo}, 64'h0000_0002_0000_000E);
        do_op("div neg", 3'd2, 32'hFFFF_FFF9, 32'd2, -1, -1, -1);
        check("div neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
        check("div ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op("div zero", 3'd2, 32'h0000_000A, 32'd0, -1, -1, -1);
        check("div zero const", {hi, lo}, 64'h0000_000A_FFFF_FFFF);
        do_op("mthi", 3'd4, 32'h1234_5678, 32'd0, -1, -1, -1);
        do_op("mtlo", 3'd5, 32'h9ABC_DEF0, 32'd0, -1, -1, -1);
        check("mt const", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        do_op("mult inj", 3'd0, 32'h0001_2345, 32'hFFFF_0003, 5, -1, -1);
        do_op("mult cancel", 3'd0, 32'h0000_0777, 32'h0000_0333, -1, 10, -1);
        do_op("divu reset", 3'd3, 32'h0000_1000, 32'h0000_0003, -1, -1, 12);
        do_op("multu small", 3'd1, 32'd6, 32'd7, -1, -1, -1);
        check("multu small const", {hi, lo}, 64'h0000_0000_0000_002A);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            do_op("rand", ro, ra, rb, -1, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
